// File: rtl/gpio_pkg.sv
// Shared opcode constants and FSM encoding for the GPIO output driver.
package gpio_pkg;

    localparam logic [2:0] OP_WRITE    = 3'd0;
    localparam logic [2:0] OP_SET      = 3'd1;
    localparam logic [2:0] OP_CLEAR    = 3'd2;
    localparam logic [2:0] OP_TOGGLE   = 3'd3;
    localparam logic [2:0] OP_OE_WRITE = 3'd4;
    localparam logic [2:0] OP_PULSE    = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_e;

endpackage

// File: rtl/gpio_out_driver_if.sv
// Command channel of the GPIO output driver: valid/ready handshake plus opcode, mask and data.
interface gpio_out_driver_if #(
    parameter int WIDTH = 32
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_mask,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_mask,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/gpio_pulse_timer.sv
// Loadable down-counter that saturates at zero and flags when it has reached zero.
module gpio_pulse_timer #(
    parameter int PULSE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PULSE_W-1:0] load_value,
    input  logic               enable,
    output logic               zero
);

    logic [PULSE_W-1:0] count_q;
    logic [PULSE_W-1:0] count_d;

    assign zero = (count_q == {PULSE_W{1'b0}});

    // Next count: load wins, otherwise decrement while enabled and not yet at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && !zero) begin
            count_d = count_q - {{(PULSE_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {PULSE_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gpio_out_driver.sv
// GPIO output driver: applies masked write/set/clear/toggle/oe commands and timed pin pulses.
module gpio_out_driver
    import gpio_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PULSE_W = 16
) (
    input  logic                  io_mainClk,
    input  logic                  resetCtrl_systemReset,
    gpio_out_driver_if.slave      cmd,
    output logic [WIDTH-1:0]      io_gpio_write,
    output logic [WIDTH-1:0]      io_gpio_writeEnable,
    output logic                  busy
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] oe_d;
    logic [WIDTH-1:0] pulse_mask_q;
    logic [WIDTH-1:0] pulse_mask_d;
    logic             accept_s;
    logic             timer_load_s;
    logic             timer_en_s;
    logic             timer_zero_s;

    assign cmd.cmd_ready           = (state_q == ST_IDLE);
    assign busy                    = (state_q == ST_PULSE);
    assign io_gpio_write           = out_q;
    assign io_gpio_writeEnable     = oe_q;
    assign accept_s                = cmd.cmd_valid && (state_q == ST_IDLE);

    gpio_pulse_timer #(
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk        (io_mainClk),
        .rst        (resetCtrl_systemReset),
        .load       (timer_load_s),
        .load_value (cmd.cmd_data[PULSE_W-1:0]),
        .enable     (timer_en_s),
        .zero       (timer_zero_s)
    );

    // Command decode and pulse sequencing; a pulse toggles its pins on entry and again on timeout.
    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        oe_d         = oe_q;
        pulse_mask_d = pulse_mask_q;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd.cmd_op)
                        OP_WRITE:    out_d = (out_q & ~cmd.cmd_mask) | (cmd.cmd_data & cmd.cmd_mask);
                        OP_SET:      out_d = out_q | cmd.cmd_mask;
                        OP_CLEAR:    out_d = out_q & ~cmd.cmd_mask;
                        OP_TOGGLE:   out_d = out_q ^ cmd.cmd_mask;
                        OP_OE_WRITE: oe_d  = (oe_q & ~cmd.cmd_mask) | (cmd.cmd_data & cmd.cmd_mask);
                        OP_PULSE: begin
                            out_d        = out_q ^ cmd.cmd_mask;
                            pulse_mask_d = cmd.cmd_mask;
                            timer_load_s = 1'b1;
                            state_d      = ST_PULSE;
                        end
                        default: begin
                            // Reserved opcodes complete the handshake without side effects.
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (timer_zero_s) begin
                    out_d   = out_q ^ pulse_mask_q;
                    state_d = ST_IDLE;
                end else begin
                    timer_en_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and pin registers; reset overrides any command in the same cycle.
    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            state_q      <= ST_IDLE;
            out_q        <= {WIDTH{1'b0}};
            oe_q         <= {WIDTH{1'b0}};
            pulse_mask_q <= {WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            oe_q         <= oe_d;
            pulse_mask_q <= pulse_mask_d;
        end
    end

endmodule

// File: tb/tb_gpio_out_driver.sv
// Directed, table-driven bench for gpio_out_driver with hand-written pulse and reset sequences.
module tb_gpio_out_driver;

    localparam int WIDTH   = 32;
    localparam int PULSE_W = 16;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  gpio_w;
    logic [WIDTH-1:0]  gpio_oe;
    logic              busy;

    int n_cmp;
    int n_fail;

    gpio_out_driver_if #(.WIDTH(WIDTH)) cif ();

    gpio_out_driver #(
        .WIDTH   (WIDTH),
        .PULSE_W (PULSE_W)
    ) dut (
        .io_mainClk            (clk),
        .resetCtrl_systemReset (rst),
        .cmd                   (cif),
        .io_gpio_write         (gpio_w),
        .io_gpio_writeEnable   (gpio_oe),
        .busy                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] mask;
        logic [31:0] data;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] mask, input logic [31:0] data);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_mask  = mask;
        cif.cmd_data  = data;
        step();
        cif.cmd_valid = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{"write_a5",      3'd0, 32'h0000_00FF, 32'h0000_00A5, 32'h0000_00A5, 32'h0000_0000};
        vecs[1] = '{"write_full",    3'd0, 32'hFFFF_FFFF, 32'hF0F0_0000, 32'hF0F0_0000, 32'h0000_0000};
        vecs[2] = '{"set",           3'd1, 32'h0000_000F, 32'h0000_0000, 32'hF0F0_000F, 32'h0000_0000};
        vecs[3] = '{"clear",         3'd2, 32'hF000_0000, 32'hFFFF_FFFF, 32'h00F0_000F, 32'h0000_0000};
        vecs[4] = '{"toggle",        3'd3, 32'h0000_0003, 32'h0000_0000, 32'h00F0_000C, 32'h0000_0000};
        vecs[5] = '{"oe_write",      3'd4, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h00F0_000C, 32'h0000_FFFF};
        vecs[6] = '{"op7_noop",      3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h00F0_000C, 32'h0000_FFFF};
        vecs[7] = '{"op6_noop",      3'd6, 32'hFFFF_FFFF, 32'h1234_5678, 32'h00F0_000C, 32'h0000_FFFF};
        vecs[8] = '{"write_mask0",   3'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h00F0_000C, 32'h0000_FFFF};
        vecs[9] = '{"oe_partial",    3'd4, 32'hFF00_0000, 32'hAA00_0000, 32'h00F0_000C, 32'hAA00_FFFF};

        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 3'd0;
        cif.cmd_mask  = 32'h0;
        cif.cmd_data  = 32'h0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_out",   gpio_w,  32'h0);
        chk("reset_oe",    gpio_oe, 32'h0);
        chk("reset_ready", {31'd0, cif.cmd_ready}, 32'd1);
        chk("reset_busy",  {31'd0, busy},          32'd0);

        // Back-to-back single-cycle commands from the table.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].mask, vecs[i].data);
            chk({vecs[i].name, "_out"},   gpio_w,  vecs[i].exp_out);
            chk({vecs[i].name, "_oe"},    gpio_oe, vecs[i].exp_oe);
            chk({vecs[i].name, "_ready"}, {31'd0, cif.cmd_ready}, 32'd1);
        end

        // Pulse of data+1 = 5 cycles on mask 0x3 starting from out = 0x1.
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("pre_pulse_out", gpio_w, 32'h1);
        send(3'd5, 32'h0000_0003, 32'h0000_0004);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("pulse5_out_c%0d", c),   gpio_w, 32'h2);
            chk($sformatf("pulse5_busy_c%0d", c),  {31'd0, busy}, 32'd1);
            chk($sformatf("pulse5_ready_c%0d", c), {31'd0, cif.cmd_ready}, 32'd0);
            if (c < 4) step();
        end
        step();
        chk("pulse5_end_out",  gpio_w, 32'h1);
        chk("pulse5_end_busy", {31'd0, busy}, 32'd0);
        chk("pulse5_end_oe",   gpio_oe, 32'hAA00_FFFF);

        // One-cycle pulse with a TOGGLE held valid throughout.
        send(3'd5, 32'h0000_0001, 32'h0000_0000);
        chk("pulse1_out", gpio_w, 32'h0);
        chk("pulse1_busy", {31'd0, busy}, 32'd1);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 3'd3;
        cif.cmd_mask  = 32'h0000_0004;
        cif.cmd_data  = 32'h0;
        step();
        chk("held_toggle_ignored", gpio_w, 32'h1);
        chk("held_toggle_ready", {31'd0, cif.cmd_ready}, 32'd1);
        step();
        cif.cmd_valid = 1'b0;
        chk("held_toggle_applied", gpio_w, 32'h5);
        step();
        chk("held_toggle_once", gpio_w, 32'h5);

        // Pulse with an empty mask still runs its timer and touches nothing.
        send(3'd5, 32'h0000_0000, 32'h0000_0002);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("mask0_out_c%0d", c),  gpio_w, 32'h5);
            chk($sformatf("mask0_busy_c%0d", c), {31'd0, busy}, 32'd1);
            if (c < 2) step();
        end
        step();
        chk("mask0_end_busy", {31'd0, busy}, 32'd0);
        chk("mask0_end_out",  gpio_w, 32'h5);

        // Reset in the 3rd cycle of a long pulse, with a command held during reset.
        send(3'd5, 32'h0000_00FF, 32'h0000_000A);
        chk("long_pulse_out", gpio_w, 32'h0000_00FA);
        step();
        step();
        rst = 1'b1;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 3'd0;
        cif.cmd_mask  = 32'hFFFF_FFFF;
        cif.cmd_data  = 32'hFFFF_FFFF;
        step();
        rst = 1'b0;
        cif.cmd_valid = 1'b0;
        chk("midpulse_rst_out",   gpio_w,  32'h0);
        chk("midpulse_rst_oe",    gpio_oe, 32'h0);
        chk("midpulse_rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
        chk("midpulse_rst_busy",  {31'd0, busy}, 32'd0);
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("no_restore_c%0d", c), gpio_w, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
